// File: rtl/ikari_sprite_linebuffer_if.sv
// Renderer/mixer-side signals of the sprite line buffer.
// The master drives the strobes and write data; the slave is the line buffer.
interface ikari_sprite_linebuffer_if #(
  parameter int XW = 9
);
  logic          CK1;
  logic          LINE_START;
  logic          RD_EN;
  logic          WR_EN;
  logic [XW-1:0] WR_X;
  logic [7:0]    WR_PIX;
  logic [7:0]    L1D;
  logic          BUSY;
  logic          RD_BANK;

  modport master (
    output CK1, LINE_START, RD_EN, WR_EN, WR_X, WR_PIX,
    input  L1D, BUSY, RD_BANK
  );

  modport slave (
    input  CK1, LINE_START, RD_EN, WR_EN, WR_X, WR_PIX,
    output L1D, BUSY, RD_BANK
  );
endinterface

// File: rtl/ikari_sprite_linebuffer.sv
// Double-buffered sprite line buffer: the renderer fills one bank while the mixer
// reads the other, and every location read is restored to the transparent code.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | post-reset sweep, CLR_VAL written to both banks at clr_a
// S_RUN   | normal operation: sprite writes, pixel reads, bank swaps
module ikari_sprite_linebuffer #(
  parameter int            XW      = 9,
  parameter logic [XW-1:0] RD_X0   = '0,
  parameter logic [7:0]    CLR_VAL = 8'h7F
) (
  input  logic                    clk,
  input  logic                    VIDEO_RSTn,
  ikari_sprite_linebuffer_if.slave bus
);
  localparam int DEPTH = 1 << XW;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t        state, state_nx;
  logic [XW-1:0] clr_a;
  logic [XW-1:0] rd_x;
  logic [XW-1:0] clr_x;
  logic          rd_bank;
  logic          rd_pend;
  logic          blank_pend;
  logic [7:0]    rd_data;
  logic [7:0]    l1d;

  logic [7:0]    mem0 [DEPTH];
  logic [7:0]    mem1 [DEPTH];

  logic          run;
  logic          do_swap;
  logic          do_read;
  logic          do_blank;
  logic          spr_we;
  logic          we0, we1;
  logic [XW-1:0] addr0, addr1;
  logic [7:0]    data0, data1;

  always_comb begin
    state_nx = state;
    run      = 1'b0;
    do_swap  = 1'b0;
    do_read  = 1'b0;
    do_blank = 1'b0;
    spr_we   = 1'b0;
    we0      = 1'b0;
    we1      = 1'b0;
    addr0    = bus.WR_X;
    addr1    = bus.WR_X;
    data0    = bus.WR_PIX;
    data1    = bus.WR_PIX;

    case (state)
      S_CLEAR: begin
        if (clr_a == {XW{1'b1}}) state_nx = S_RUN;
      end
      S_RUN: begin
        run = 1'b1;
      end
      default: state_nx = S_CLEAR;
    endcase

    // A reset edge drops the in-flight clear-behind as well as the sweep step.
    if (VIDEO_RSTn) begin
      do_swap  = run & bus.LINE_START;
      do_read  = run & bus.CK1 & bus.RD_EN & ~bus.LINE_START;
      do_blank = run & bus.CK1 & ~bus.RD_EN & ~bus.LINE_START;
      spr_we   = run & bus.WR_EN & (bus.WR_PIX[3:0] != 4'hF);

      if (state == S_CLEAR) begin
        we0   = 1'b1;
        we1   = 1'b1;
        addr0 = clr_a;
        addr1 = clr_a;
        data0 = CLR_VAL;
        data1 = CLR_VAL;
      end else if (rd_bank) begin
        we1   = rd_pend;
        addr1 = clr_x;
        data1 = CLR_VAL;
        we0   = spr_we;
      end else begin
        we0   = rd_pend;
        addr0 = clr_x;
        data0 = CLR_VAL;
        we1   = spr_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!VIDEO_RSTn) begin
      state      <= S_CLEAR;
      clr_a      <= '0;
      rd_x       <= RD_X0;
      clr_x      <= '0;
      rd_bank    <= 1'b0;
      rd_pend    <= 1'b0;
      blank_pend <= 1'b0;
      l1d        <= CLR_VAL;
    end else begin
      state      <= state_nx;
      rd_pend    <= do_read;
      blank_pend <= do_blank;

      if (state == S_CLEAR) clr_a <= clr_a + 1'b1;

      if (do_swap) begin
        rd_bank <= ~rd_bank;
        rd_x    <= RD_X0;
      end else if (do_read) begin
        clr_x <= rd_x;
        rd_x  <= rd_x + 1'b1;
      end

      if (rd_pend)         l1d <= rd_data;
      else if (blank_pend) l1d <= CLR_VAL;
    end
  end

  // Storage: one write port per bank plus a shared registered read port.
  always_ff @(posedge clk) begin
    if (we0) mem0[addr0] <= data0;
    if (we1) mem1[addr1] <= data1;
    if (do_read) rd_data <= rd_bank ? mem1[rd_x] : mem0[rd_x];
  end

  assign bus.L1D     = l1d;
  assign bus.BUSY    = (state == S_CLEAR);
  assign bus.RD_BANK = rd_bank;
endmodule
